// File: rtl/systolic_result_drain.sv
// Result drain for a systolic array: walks y_index over all N rows,
// captures each selected row from y_out and hands it downstream with a
// valid/ready handshake. One row needs at least two cycles: capture, then send.

package systolic_array_pkg;
  typedef logic [15:0] word_t;
endpackage

// One column lane of the captured row register; loads only on capture.
module systolic_result_drain_lane
  import systolic_array_pkg::*;
(
  input  logic  clk,
  input  logic  n_rst,
  input  logic  cap_en,
  input  word_t d,
  output word_t q
);
  // Hold the last captured word; an abort leaves it untouched
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      q <= '0;
    else if (cap_en) q <= d;
  end
endmodule

module systolic_result_drain
  import systolic_array_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  drain_start,
  input  logic                  drain_abort,
  input  logic                  array_stall,
  input  word_t [N-1:0]         y_out,
  output logic [$clog2(N)-1:0]  y_index,
  input  logic                  row_ready,
  output logic                  row_valid,
  output word_t [N-1:0]         row_data,
  output logic [$clog2(N)-1:0]  row_idx,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

  state_t state, state_nxt;
  logic   cap_en;
  logic   idx_last;

  assign idx_last = (y_index == IW'(N - 1));
  // Abort wins over every other input, so it also gates the capture strobe
  assign cap_en   = (state == CAPTURE) && !array_stall && !drain_abort;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort forces IDLE from anywhere
  always_comb begin
    state_nxt = state;
    if (drain_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (drain_start) state_nxt = CAPTURE;
        CAPTURE: if (!array_stall) state_nxt = SEND;
        SEND:    if (row_ready) state_nxt = idx_last ? DONE : CAPTURE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Row index counter and handshake flags; the counter wraps to 0 after the last row
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      y_index   <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
    end else if (drain_abort) begin
      y_index   <= '0;
      row_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (drain_start) y_index <= '0;
        CAPTURE: if (!array_stall) begin
          row_valid <= 1'b1;
          row_idx   <= y_index;
        end
        SEND: if (row_ready) begin
          row_valid <= 1'b0;
          y_index   <= idx_last ? '0 : y_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-column capture registers
  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_result_drain_lane u_lane (
      .clk   (clk),
      .n_rst (n_rst),
      .cap_en(cap_en),
      .d     (y_out[i]),
      .q     (row_data[i])
    );
  end

  assign row_last = row_valid && (row_idx == IW'(N - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain at N=4: transaction-level reference model,
// per-cycle compare, directed scenarios with literal expectations, random phase.
module tb_systolic_result_drain;
  import systolic_array_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic clk = 0, n_rst = 0;
  logic drain_start = 0, drain_abort = 0, array_stall = 0, row_ready = 0;
  word_t [N-1:0] y_out, row_data;
  logic [IW-1:0] y_index, row_idx;
  logic row_valid, row_last, busy, done;
  int unsigned salt = 0;

  systolic_result_drain #(.N(N)) dut (
    .clk(clk), .n_rst(n_rst), .drain_start(drain_start), .drain_abort(drain_abort),
    .array_stall(array_stall), .y_out(y_out), .y_index(y_index), .row_ready(row_ready),
    .row_valid(row_valid), .row_data(row_data), .row_idx(row_idx), .row_last(row_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Array row r holds {N*r+N-1 .. N*r} plus a salt
  function automatic word_t [N-1:0] row_of(input int r, input int unsigned s);
    word_t [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = word_t'(N * r + k + int'(s));
    return v;
  endfunction

  always_comb y_out = row_of(int'(y_index), salt);

  // Reference model: a drain is a list of rows 0..N-1, each fetched (when the
  // array is not stalled) and then offered until accepted; a done pulse follows
  // the final acceptance. Abort or reset discards the drain.
  bit            m_active, m_fetching, m_valid, m_done;
  int            m_row, m_ridx;
  word_t [N-1:0] m_data;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active = 0; m_fetching = 0; m_valid = 0; m_done = 0;
      m_row = 0; m_ridx = 0; m_data = '0;
    end else if (drain_abort) begin
      m_active = 0; m_fetching = 0; m_valid = 0; m_done = 0; m_row = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (drain_start) begin m_active = 1; m_fetching = 1; m_row = 0; end
    end else if (m_fetching) begin
      if (!array_stall) begin
        m_data = row_of(m_row, salt); m_ridx = m_row; m_valid = 1; m_fetching = 0;
      end
    end else if (row_ready) begin
      m_valid = 0;
      if (m_row == N - 1) begin m_row = 0; m_active = 0; m_done = 1; end
      else begin m_row++; m_fetching = 1; end
    end
  end

  int n_cmp = 0, n_bad = 0, dones = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("y_index",   64'(y_index),   64'(m_row));
      chk("row_valid", 64'(row_valid), 64'(m_valid));
      chk("row_idx",   64'(row_idx),   64'(m_ridx));
      chk("row_data",  64'(row_data),  64'(m_data));
      chk("row_last",  64'(row_last),  64'(m_valid && m_ridx == N - 1));
      chk("busy",      64'(busy),      64'(m_active || m_done));
      chk("done",      64'(done),      64'(m_done));
    end
    if (done) dones++;
  end

  task automatic wait_row(input int r);
    int n = 0;
    while (!(row_valid && int'(row_idx) == r) && n < 60) begin @(negedge clk); n++; end
    chk("wait_row_timeout", 64'(n < 60), 64'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("wait_idle_timeout", 64'(n < 100), 64'(1));
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(row_valid), 64'(0));
    chk("rst_data",  64'(row_data),  64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    n_rst = 1; chk_en = 1;
    @(negedge clk);

    // Full drain: start sampled at cycle 0
    drain_start = 1; row_ready = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); drain_start = 0;
      chk("full_valid", 64'(row_valid), 64'(c == 2 || c == 4 || c == 6 || c == 8));
      if (c == 2 || c == 4 || c == 6 || c == 8) begin
        chk("full_idx",  64'(row_idx),  64'((c - 2) / 2));
        chk("full_data", 64'(row_data), 64'(row_of((c - 2) / 2, 0)));
      end
      chk("full_last", 64'(row_last), 64'(c == 8));
      chk("full_done", 64'(done),     64'(c == 9));
      chk("full_busy", 64'(busy),     64'(c >= 1 && c <= 9));
    end

    // Backpressure on row 1
    drain_start = 1; @(negedge clk); drain_start = 0;
    wait_row(1); row_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_data",  64'(row_data),  64'({16'd7, 16'd6, 16'd5, 16'd4}));
      chk("bp_idx",   64'(row_idx),   64'(1));
      chk("bp_valid", 64'(row_valid), 64'(1));
    end
    row_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("bp_row2", 64'(row_valid && row_idx == 2), 64'(1));
    wait_idle();

    // Stall while capturing row 2
    drain_start = 1; @(negedge clk); drain_start = 0;
    wait_row(1); array_stall = 1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_novalid", 64'(row_valid), 64'(0));
    end
    array_stall = 0;
    @(negedge clk);
    chk("stall_row2", 64'(row_valid && row_idx == 2), 64'(1));
    chk("stall_data", 64'(row_data), 64'({16'd11, 16'd10, 16'd9, 16'd8}));
    wait_idle();

    // Abort during SEND of row 1, then a clean drain
    d0 = dones;
    drain_start = 1; @(negedge clk); drain_start = 0;
    wait_row(1); drain_abort = 1; row_ready = 0;
    @(negedge clk); drain_abort = 0;
    chk("abort_valid", 64'(row_valid), 64'(0));
    chk("abort_yidx",  64'(y_index),   64'(0));
    chk("abort_busy",  64'(busy),      64'(0));
    repeat (4) @(negedge clk);
    chk("abort_nodone", 64'(dones - d0), 64'(0));
    row_ready = 1; drain_start = 1; @(negedge clk); drain_start = 0;
    wait_idle();
    chk("abort_redrain_done", 64'(dones - d0), 64'(1));

    // Start while busy is ignored; start with abort in IDLE stays IDLE
    d0 = dones;
    drain_start = 1; @(negedge clk); drain_start = 0;
    repeat (2) @(negedge clk);
    drain_start = 1; @(negedge clk); drain_start = 0;
    wait_idle(); repeat (3) @(negedge clk);
    chk("prio_one_done", 64'(dones - d0), 64'(1));
    drain_start = 1; drain_abort = 1; @(negedge clk);
    drain_start = 0; drain_abort = 0;
    chk("prio_abort_idle", 64'(busy), 64'(0));

    // Reset mid-SEND
    row_ready = 0; drain_start = 1; @(negedge clk); drain_start = 0;
    wait_row(0);
    #2 n_rst = 0; #1;
    chk("rstmid_valid", 64'(row_valid), 64'(0));
    chk("rstmid_data",  64'(row_data),  64'(0));
    chk("rstmid_busy",  64'(busy),      64'(0));
    chk("rstmid_yidx",  64'(y_index),   64'(0));
    @(negedge clk); @(negedge clk); n_rst = 1; row_ready = 1;
    d0 = dones;
    repeat (4) @(negedge clk);
    chk("rstmid_idle", 64'(busy || (dones != d0)), 64'(0));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      drain_start = ($urandom % 6) == 0;
      drain_abort = ($urandom % 40) == 0;
      array_stall = ($urandom % 3) == 0;
      row_ready   = ($urandom % 4) != 0;
      salt        = $urandom % 1000;
      @(negedge clk);
    end
    drain_start = 0; drain_abort = 0; array_stall = 0; row_ready = 1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter N, default 64, giving array dimension (rows and columns); legal N >= 2, power of two.
REQ-002 SHALL use word_t from systolic_array_pkg for all data elements.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port drain_start  input  1  one-cycle request to read all N result rows.
REQ-006 SHALL have port drain_abort  input  1  cancel drain in progress.
REQ-007 SHALL have port array_stall  input  1  array busy; results not readable.
REQ-008 SHALL have port y_out  input  N x word_t  array row selected by y_index, combinational from y_index.
REQ-009 SHALL have port y_index  output  $clog2(N)  row select driven to the array, registered.
REQ-010 SHALL have port row_ready  input  1  downstream accepts row.
REQ-011 SHALL have port row_valid  output  1  row_data/row_idx valid.
REQ-012 SHALL have port row_data  output  N x word_t  captured result row.
REQ-013 SHALL have port row_idx  output  $clog2(N)  index of row_data.
REQ-014 SHALL have port row_last  output  1  row_valid and row_idx == N-1.
REQ-015 SHALL have port busy  output  1  state != IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last row accepted.

Function
REQ-017 SHALL implement FSM with states IDLE, CAPTURE, SEND, DONE.
REQ-018 IDLE: drain_start=1 and drain_abort=0 -> CAPTURE, with row index counter (drives y_index) = 0.
REQ-019 CAPTURE: array_stall=0 -> latch row_data <= y_out, row_idx <= y_index, set row_valid -> SEND.
REQ-020 CAPTURE with array_stall=1 SHALL hold state; no capture; row_valid stays 0.
REQ-021 SEND: row_valid=1; row_ready=1 and index < N-1 -> increment index, clear row_valid -> CAPTURE.
REQ-022 SEND: row_ready=1 and index == N-1 -> clear row_valid, index <= 0 -> DONE.
REQ-023 SEND with row_ready=0 SHALL hold row_data, row_idx, row_valid unchanged; array_stall ignored in SEND.
REQ-024 DONE SHALL assert done for exactly one cycle -> IDLE.
REQ-025 Throughput: one row per 2 cycles minimum; first row_valid 2 cycles after drain_start sampled.
REQ-026 drain_start SHALL be ignored in all states except IDLE.
REQ-027 drain_abort=1 in any state SHALL force IDLE next cycle: row_valid=0, index=0, no done pulse; row_data retains last value.
REQ-028 drain_abort SHALL take priority over drain_start, row_ready and array_stall in the same cycle.
REQ-029 y_index SHALL equal the index counter at all times; index SHALL never exceed N-1.
REQ-030 row_last SHALL be combinational from row_valid and row_idx.

Reset
REQ-031 n_rst=0 SHALL asynchronously set state IDLE, y_index=0, row_valid=0, row_data=0, row_idx=0, done=0; busy=0, row_last=0 follow.
REQ-032 Reset mid-drain SHALL discard the drain; no done pulse after release.

Verification (N=4, y_out row r = {4r+3,4r+2,4r+1,4r})
REQ-033 Reset: assert n_rst mid-SEND -> all outputs 0 same cycle, stay IDLE after release.
REQ-034 Full drain, row_ready=1, array_stall=0, start at cycle 0 -> row_valid at cycles 2,4,6,8 with row_idx 0..3 and matching data; row_last at 8; done at 9; busy 1..9.
REQ-035 Backpressure: row_ready=0 for 5 cycles on row 1 -> row_data {7,6,5,4}, row_idx 1 stable; row 2 appears 2 cycles after ready.
REQ-036 Stall: array_stall=1 for 3 cycles entering CAPTURE for row 2 -> no row_valid during stall; row 2 valid the cycle after capture once stall=0.
REQ-037 Abort: drain_abort during SEND of row 1 -> IDLE next cycle, row_valid=0, y_index=0, no done; new drain_start then yields rows 0..3.
REQ-038 Priority: drain_start while busy ignored (one done per drain); drain_start and drain_abort together in IDLE -> stays IDLE.
